// File: rtl/condicionador_botoes_if.sv
// condicionador_botoes_if
// Groups the button-conditioner signals into one bundle.
//   master : the side that drives the raw buttons and control (control unit / bench)
//   slave  : the conditioner itself
// Signals:
//   botoes_brutos  [7:0]  raw button levels, active-high, asynchronous to clk
//   habilitar             enables press-pulse generation
//   limpar_jogadas        synchronous clear of the move counter
//   pulsos         [7:0]  one-cycle press pulses (to matriz_leds.botoes)
//   estavel        [7:0]  debounced button levels
//   jogadas        [7:0]  saturating move counter
interface condicionador_botoes_if;
    logic [7:0] botoes_brutos;
    logic       habilitar;
    logic       limpar_jogadas;
    logic [7:0] pulsos;
    logic [7:0] estavel;
    logic [7:0] jogadas;

    modport master (
        output botoes_brutos,
        output habilitar,
        output limpar_jogadas,
        input  pulsos,
        input  estavel,
        input  jogadas
    );

    modport slave (
        input  botoes_brutos,
        input  habilitar,
        input  limpar_jogadas,
        output pulsos,
        output estavel,
        output jogadas
    );
endinterface

// File: rtl/condicionador_botoes.sv
// condicionador_botoes
// Input stage for matriz_leds: two-flop synchronizer, per-button debounce,
// rising-edge press pulses and a saturating move counter.
// Ports:
//   clk   FPGA main clock
//   rst   asynchronous active-high reset, clears every register
//   bus   condicionador_botoes_if.slave (botoes_brutos, habilitar,
//         limpar_jogadas in; pulsos, estavel, jogadas out)
// Parameters:
//   DEBOUNCE_CICLOS  consecutive mismatching cycles needed to change a
//                    stable level (2 .. 2**CNT_W-1)
//   CNT_W            width of each per-button debounce counter
module condicionador_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    condicionador_botoes_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [7:0] s1_reg;
    logic [7:0] s2_reg;
    logic [7:0] estavel_vec;
    logic [7:0] estavel_d_reg;
    logic [7:0] pulsos_reg;
    logic [7:0] pulsos_next;
    logic [7:0] jogadas_reg;
    logic [7:0] jogadas_next;

    // Two-flop synchronizer; only s2 is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= bus.botoes_brutos;
            s2_reg <= s1_reg;
        end
    end

    // Independent debounce per button. A single matching cycle restarts
    // the count; the counter stops at CNT_MAX so it can never wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             estavel_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg     <= '0;
                    estavel_reg <= 1'b0;
                end else if (s2_reg[gi] == estavel_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_MAX) begin
                    estavel_reg <= s2_reg[gi];
                    cnt_reg     <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign estavel_vec[gi] = estavel_reg;
        end
    endgenerate

    // Press pulses: rising edge of the debounced level, gated by habilitar.
    // A press seen while disabled is dropped, not held for later.
    always_comb begin
        pulsos_next = {8{bus.habilitar}} & estavel_vec & ~estavel_d_reg;
    end

    // Move counter: clear wins over increment; simultaneous pulses count once.
    always_comb begin
        jogadas_next = jogadas_reg;
        if (bus.limpar_jogadas) begin
            jogadas_next = '0;
        end else if ((pulsos_reg != 8'd0) && (jogadas_reg != 8'hFF)) begin
            jogadas_next = jogadas_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estavel_d_reg <= '0;
            pulsos_reg    <= '0;
            jogadas_reg   <= '0;
        end else begin
            estavel_d_reg <= estavel_vec;
            pulsos_reg    <= pulsos_next;
            jogadas_reg   <= jogadas_next;
        end
    end

    assign bus.pulsos  = pulsos_reg;
    assign bus.estavel = estavel_vec;
    assign bus.jogadas = jogadas_reg;

endmodule
